// File: rtl/gpu_cmd_scheduler.sv
// ============================================================================
// Module  : gpu_cmd_scheduler
// Purpose : FIFO-buffered fill/blit command sequencer feeding the GPU
//           operations engine. Optional macro GPU_CMD_STATS_EN adds counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module gpu_cmd_scheduler #(
    parameter int DEPTH = 4,
    parameter int LVL_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_op,
    input  logic [8:0]       cmd_x1,
    input  logic [8:0]       cmd_x2,
    input  logic [7:0]       cmd_y1,
    input  logic [7:0]       cmd_y2,
    input  logic             cmd_fill_value,
    input  logic [8:0]       cmd_blit_w,
    input  logic [7:0]       cmd_blit_h,
    output logic [8:0]       eng_x1,
    output logic [8:0]       eng_x2,
    output logic [7:0]       eng_y1,
    output logic [7:0]       eng_y2,
    output logic             eng_fill_value,
    output logic [8:0]       eng_blit_w,
    output logic [7:0]       eng_blit_h,
    output logic             eng_start_fill,
    output logic             eng_start_blit,
    input  logic             eng_busy,
    input  logic             eng_error,
    output logic             idle,
    output logic             done_pulse,
    output logic             err_pulse,
    output logic             err_sticky,
    input  logic             err_clear,
`ifdef GPU_CMD_STATS_EN
    output logic [15:0]      stat_done_cnt,
    output logic [15:0]      stat_err_cnt,
`endif
    output logic [LVL_W-1:0] queue_level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CMD_W = 53;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ISSUE     = 2'd1;
    localparam logic [1:0] ST_CHECK     = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

    logic [CMD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;
    logic [1:0]       state;
    logic             cur_blit;
    logic [CMD_W-1:0] head;
    logic             push;
    logic             pop;
    logic             set_err;

    assign head        = mem[rd_ptr];
    assign cmd_ready   = (level != LVL_W'(DEPTH));
    assign push        = cmd_valid & cmd_ready;
    assign pop         = (state == ST_IDLE) & (level != '0) & ~eng_busy;
    assign set_err     = (state == ST_CHECK) & ~eng_busy & eng_error;
    assign idle        = (level == '0) & (state == ST_IDLE);
    assign queue_level = level;

    // Storage is deliberately not reset; validity is tracked by level alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_op, cmd_x1, cmd_x2, cmd_y1, cmd_y2,
                            cmd_fill_value, cmd_blit_w, cmd_blit_h};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            cur_blit       <= 1'b0;
            eng_x1         <= '0;
            eng_x2         <= '0;
            eng_y1         <= '0;
            eng_y2         <= '0;
            eng_fill_value <= 1'b0;
            eng_blit_w     <= '0;
            eng_blit_h     <= '0;
            eng_start_fill <= 1'b0;
            eng_start_blit <= 1'b0;
            done_pulse     <= 1'b0;
            err_pulse      <= 1'b0;
        end else begin
            eng_start_fill <= 1'b0;
            eng_start_blit <= 1'b0;
            done_pulse     <= 1'b0;
            err_pulse      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        {cur_blit, eng_x1, eng_x2, eng_y1, eng_y2,
                         eng_fill_value, eng_blit_w, eng_blit_h} <= head;
                        eng_start_fill <= ~head[CMD_W-1];
                        eng_start_blit <= head[CMD_W-1];
                        state          <= ST_ISSUE;
                    end
                end
                ST_ISSUE: state <= ST_CHECK;
                ST_CHECK: begin
                    if (eng_busy) begin
                        state <= ST_WAIT_DONE;
                    end else if (eng_error) begin
                        err_pulse <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        // Engine ignored the start: retry the same command.
                        eng_start_fill <= ~cur_blit;
                        eng_start_blit <= cur_blit;
                        state          <= ST_ISSUE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!eng_busy) begin
                        done_pulse <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A new error takes priority over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         err_sticky <= 1'b0;
        else if (set_err)   err_sticky <= 1'b1;
        else if (err_clear) err_sticky <= 1'b0;
    end

`ifdef GPU_CMD_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_done_cnt <= '0;
            stat_err_cnt  <= '0;
        end else begin
            if (done_pulse && stat_done_cnt != 16'hFFFF) stat_done_cnt <= stat_done_cnt + 16'd1;
            if (err_pulse && stat_err_cnt != 16'hFFFF)   stat_err_cnt  <= stat_err_cnt + 16'd1;
        end
    end
`endif

endmodule

`default_nettype wire
